// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-granular arbiter sharing one UART TX byte port
// An owner keeps the TX path until it hands over a last byte or stalls for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 2160
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    tx_valid,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_ready,
    output logic                    timeout
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] C_STALL_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_owner;
    logic [PW-1:0]     w_owner_nxt;
    logic [PW-1:0]     r_rr_ptr;
    logic [PW-1:0]     w_rr_nxt;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  w_grant_nxt;
    logic [CW-1:0]     r_stall_cnt;
    logic [CW-1:0]     w_stall_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;

    logic [PW-1:0]     w_pick;
    logic              w_pick_found;
    logic              w_owner_valid;
    logic              w_owner_last;
    logic              w_xfer;

    function automatic logic [PW-1:0] wrap_idx(input int v);
        return PW'(v % N_REQ);
    endfunction

    // Walk from the farthest candidate to the nearest so the nearest valid index wins.
    always_comb begin
        w_pick       = '0;
        w_pick_found = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_valid[wrap_idx(int'(r_rr_ptr) + i)]) begin
                w_pick       = wrap_idx(int'(r_rr_ptr) + i);
                w_pick_found = 1'b1;
            end
        end
    end

    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_last  = req_last[r_owner];
    assign w_xfer        = (r_state == S_LOCK) && w_owner_valid && tx_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_rr_nxt      = r_rr_ptr;
        w_grant_nxt   = r_grant;
        w_stall_nxt   = r_stall_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall_nxt = '0;
                if (w_pick_found) begin
                    w_owner_nxt         = w_pick;
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_pick] = 1'b1;
                    w_state_nxt         = S_LOCK;
                end
            end
            S_LOCK: begin
                if (w_xfer) begin
                    w_stall_nxt = '0;
                    if (w_owner_last) begin
                        w_rr_nxt    = r_owner;
                        w_grant_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else if (!w_owner_valid) begin
                    // Only an absent byte counts as a stall; a busy UART does not.
                    if (r_stall_cnt == C_STALL_LAST) begin
                        w_timeout_nxt = 1'b1;
                        w_rr_nxt      = r_owner;
                        w_grant_nxt   = '0;
                        w_stall_nxt   = '0;
                        w_state_nxt   = S_IDLE;
                    end else if (r_stall_cnt != '1) begin
                        w_stall_nxt = r_stall_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= PW'(N_REQ - 1);
            r_grant     <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_grant     <= w_grant_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        if (r_state == S_LOCK) begin
            req_ready[r_owner] = tx_ready;
            tx_valid           = w_owner_valid;
            tx_data            = req_data[int'(r_owner)*DATA_W +: DATA_W];
        end
    end

    assign grant   = r_grant;
    assign timeout = r_timeout;

endmodule
